// File: rtl/q15_dot_accum.sv
// q15_dot_accum: sequential signed Q8.24 dot product. One shared 32x32
// multiplier feeds a Q16.48 accumulator. The result is saturated to the
// symmetric 64-bit range used by the Q15-to-FP32 converter.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operand vectors present
//   in_ready   block can accept operands (decoded from state)
//   a_data     vector A, element i at [32*i+31:32*i], signed Q8.24
//   b_data     vector B, same packing as a_data
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   q15_data   signed Q16.48 result, registered
//   overflow   result was saturated, qualified by out_valid
module q15_dot_accum #(
    parameter int unsigned ELEM_COUNT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [32*ELEM_COUNT-1:0]  a_data,
    input  logic [32*ELEM_COUNT-1:0]  b_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               q15_data,
    output logic                      overflow
);

    localparam int unsigned VEC_W = 32 * ELEM_COUNT;
    localparam int unsigned IDX_W = (ELEM_COUNT > 1) ? $clog2(ELEM_COUNT) : 1;
    localparam int unsigned ACC_W = 67;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_accept;
    logic                      w_last;

    logic [VEC_W-1:0]          r_a;
    logic [VEC_W-1:0]          r_b;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_out_valid;
    logic [63:0]               r_q15;
    logic                      r_ovf;

    logic signed [31:0]        w_a_elem;
    logic signed [31:0]        w_b_elem;
    logic signed [63:0]        w_prod;
    logic signed [ACC_W-1:0]   w_sum;
    logic                      w_pos_sat;
    logic                      w_neg_sat;
    logic [63:0]               w_sat_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (r_idx == IDX_W'(ELEM_COUNT - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Select the current element pair from the latched operands
    always_comb begin
        w_a_elem = '0;
        w_b_elem = '0;
        for (int i = 0; i < int'(ELEM_COUNT); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_elem = r_a[32*i +: 32];
                w_b_elem = r_b[32*i +: 32];
            end
        end
    end

    assign w_prod = w_a_elem * w_b_elem;
    assign w_sum  = r_acc + ACC_W'(w_prod);

    // Above 2^63-1, or at/below -2^63 (the latter folds to -(2^63-1))
    assign w_pos_sat = ~w_sum[66] & (|w_sum[65:63]);
    assign w_neg_sat = w_sum[66] & ~((&w_sum[65:63]) & (|w_sum[62:0]));

    always_comb begin
        w_sat_q = w_sum[63:0];
        if (w_pos_sat) begin
            w_sat_q = 64'h7fff_ffff_ffff_ffff;
        end else if (w_neg_sat) begin
            w_sat_q = 64'h8000_0000_0000_0001;
        end
    end

    // Operand latch, accumulator and registered result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_q15       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= a_data;
                r_b   <= b_data;
                r_idx <= '0;
                r_acc <= '0;
            end
            if (r_state == S_MUL) begin
                r_acc <= w_sum;
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_last) begin
                r_q15       <= w_sat_q;
                r_ovf       <= w_pos_sat | w_neg_sat;
                r_out_valid <= 1'b1;
            end
            if ((r_state == S_DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign q15_data  = r_q15;
    assign overflow  = r_ovf;

endmodule
